med_seq: RTL and testbench

- Parametrised sequential median filter: successor to the combinational compare-exchange stage.
- Accepts a window of N samples serially and computes their median with a single time-shared compare-exchange unit.
- Emits the result with a one-cycle strobe.
- Sits between the pixel stream source (3x3 window gatherer) and the output pixel writer of the median image pipeline.

---
 rtl/med_pkg.sv | 32 +++
 rtl/mce_param.sv | 21 ++
 rtl/med_seq.sv | 171 +++++++++++++++++
 tb/tb_med_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/med_pkg.sv
// Shared definitions for the sequential median filter.
//
// Contents:
//   state_t      - controller states (IDLE, LOAD, SORT, DONE)
//   mid()        - index of the median slot in the window register array
//   sort_cycles()- number of compare-exchange steps in the partial bubble sort
package med_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Slot that holds the median once the upper half of the window is sorted.
    function automatic int mid(input int n);
        return (n - 1) / 2;
    endfunction

    // Pass p bubbles the largest remaining value up to slot n-1-p and needs
    // n-1-p steps; passes 0..mid are enough to settle the median slot.
    function automatic int sort_cycles(input int n);
        int total;
        total = 0;
        for (int p = 0; p <= mid(n); p++) begin
            total += n - 1 - p;
        end
        return total;
    endfunction

endpackage

// File: rtl/mce_param.sv
// Combinational compare-exchange cell.
//
// Ports:
//   A, B     - unsigned operands
//   MAX, MIN - larger and smaller operand (ties give identical values either way)
module mce_param #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] MAX,
    output logic [WIDTH-1:0] MIN
);

    logic a_greater;

    assign a_greater = (A > B);
    assign MAX       = a_greater ? A : B;
    assign MIN       = a_greater ? B : A;

endmodule

// File: rtl/med_seq.sv
// Sequential median filter: collects a window of N samples serially, then
// runs a partial bubble sort on the window registers using a single
// compare-exchange cell, and finally publishes the median with a one-cycle
// strobe.
//
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   DI   - sample data in (unsigned)
//   DSI  - sample strobe, accepted when BUSY=0
//   DO   - registered median of the last completed window
//   DSO  - one-cycle pulse when DO is updated
//   BUSY - high while sorting (SORT, DONE); DSI ignored then
module med_seq
    import med_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 9
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    output logic [WIDTH-1:0] DO,
    output logic             DSO,
    output logic             BUSY
);

    localparam int MID = mid(N);
    localparam int CW  = $clog2(N + 1);
    localparam int PW  = $clog2(MID + 1);
    localparam int IW  = $clog2(N);

    if ((N % 2) == 0 || N < 3 || WIDTH < 1) begin : g_param_check
        $error("med_seq: N must be odd and >= 3, WIDTH must be >= 1");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] r [N];
    logic [CW-1:0]    sample_cnt;
    logic [PW-1:0]    pass_cnt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_hi;
    logic [WIDTH-1:0] cx_max;
    logic [WIDTH-1:0] cx_min;
    logic             accept;
    logic             last_sample;
    logic             last_step;
    logic             final_step;

    assign idx_hi = idx + IW'(1);

    mce_param #(
        .WIDTH(WIDTH)
    ) u_mce (
        .A  (r[idx]),
        .B  (r[idx_hi]),
        .MAX(cx_max),
        .MIN(cx_min)
    );

    // Next-state logic plus the handful of decode strobes the datapath uses.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        last_sample = 1'b0;
        last_step   = 1'b0;
        final_step  = 1'b0;
        BUSY        = 1'b0;
        case (state)
            IDLE: begin
                accept = DSI;
                if (DSI) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                accept      = DSI;
                last_sample = DSI && (sample_cnt == CW'(N - 1));
                if (last_sample) begin
                    state_next = SORT;
                end
            end
            SORT: begin
                BUSY       = 1'b1;
                last_step  = (int'(idx) == N - 2 - int'(pass_cnt));
                final_step = last_step && (int'(pass_cnt) == MID);
                if (final_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                BUSY       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sample, pass and index counters. The pass counter is not advanced on
    // the final step so it never needs to represent MID+1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sample_cnt <= '0;
            pass_cnt   <= '0;
            idx        <= '0;
        end else begin
            if (accept) begin
                sample_cnt <= sample_cnt + CW'(1);
            end
            if (last_sample) begin
                pass_cnt <= '0;
                idx      <= '0;
            end
            if (state == SORT) begin
                if (last_step) begin
                    idx <= '0;
                    if (!final_step) begin
                        pass_cnt <= pass_cnt + PW'(1);
                    end
                end else begin
                    idx <= idx_hi;
                end
            end
            if (state == DONE) begin
                sample_cnt <= '0;
            end
        end
    end

    // Window registers: shift register while loading, in-place
    // compare-exchange on the (idx, idx+1) pair while sorting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < N; k++) begin
                r[k] <= '0;
            end
        end else if (accept) begin
            for (int k = N - 1; k > 0; k--) begin
                r[k] <= r[k-1];
            end
            r[0] <= DI;
        end else if (state == SORT) begin
            r[idx]    <= cx_min;
            r[idx_hi] <= cx_max;
        end
    end

    // Result register and strobe; DSO is high only in the cycle after DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DO  <= '0;
            DSO <= 1'b0;
        end else begin
            DSO <= (state == DONE);
            if (state == DONE) begin
                DO <= r[MID];
            end
        end
    end

endmodule

// File: tb/tb_med_seq.sv
// Directed and random self-checking bench for med_seq (N=9, WIDTH=8).
module tb_med_seq;

    typedef logic [7:0] win_t [9];

    logic       CLK;
    logic       RST;
    logic [7:0] DI;
    logic       DSI;
    logic [7:0] DO;
    logic       DSO;
    logic       BUSY;

    int n_compared;
    int n_mismatched;

    med_seq #(
        .WIDTH(8),
        .N    (9)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .DI  (DI),
        .DSI (DSI),
        .DO  (DO),
        .DSO (DSO),
        .BUSY(BUSY)
    );

    // 10-time-unit clock; inputs change and outputs are sampled on negedges.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case something wedges the simulation.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference median: full sort of a copy, take the middle element.
    function automatic logic [7:0] model_median(input win_t w);
        int a [9];
        int t;
        for (int i = 0; i < 9; i++) a[i] = int'(w[i]);
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 8 - p; i++) begin
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                end
            end
        end
        return 8'(a[4]);
    endfunction

    // Presents one sample for a single cycle; called on a negedge while BUSY=0.
    task automatic send_sample(input logic [7:0] v);
        DI  = v;
        DSI = 1'b1;
        @(negedge CLK);
        DSI = 1'b0;
    endtask

    // Sends a full window with random idle gaps between samples; returns at
    // the negedge right after the edge that accepted the last sample.
    task automatic send_window(input win_t w, input int min_gap, input int max_gap);
        for (int i = 0; i < 9; i++) begin
            send_sample(w[i]);
            if (i < 8 && max_gap > 0) begin
                repeat ($urandom_range(min_gap, max_gap)) @(negedge CLK);
            end
        end
    endtask

    // Counts edges from the last-sample edge up to the DSO pulse and the
    // number of cycles BUSY was observed high in between.
    task automatic wait_done(output int lat, output int busy_cnt, output bit timeout);
        lat      = 0;
        busy_cnt = 0;
        timeout  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (BUSY) busy_cnt++;
            @(negedge CLK);
            lat++;
            if (DSO) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        DSI = 1'b0;
        DI  = 8'd0;
        @(negedge CLK);
        @(negedge CLK);
        n_compared++;
        if (DO !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_do: got %0d expected 0", DO);
        end
        n_compared++;
        if (DSO !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_dso: got %0b expected 0", DSO);
        end
        n_compared++;
        if (BUSY !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_busy: got %0b expected 0", BUSY);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_ascending();
        win_t w;
        int   lat, bc;
        bit   to;
        w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_window(w, 0, 0);
        wait_done(lat, bc, to);
        n_compared++;
        if (to !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL asc_timeout: DSO not seen within 100 cycles");
        end
        n_compared++;
        if (lat !== 31) begin
            n_mismatched++;
            $display("[TB] FAIL asc_latency: got %0d expected 31", lat);
        end
        n_compared++;
        if (bc !== 31) begin
            n_mismatched++;
            $display("[TB] FAIL asc_busy_cycles: got %0d expected 31", bc);
        end
        n_compared++;
        if (DO !== 8'd5) begin
            n_mismatched++;
            $display("[TB] FAIL asc_do: got %0d expected 5", DO);
        end
        @(negedge CLK);
        n_compared++;
        if (DSO !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL asc_dso_width: got %0b expected 0", DSO);
        end
        n_compared++;
        if (DO !== 8'd5) begin
            n_mismatched++;
            $display("[TB] FAIL asc_do_hold: got %0d expected 5", DO);
        end
    endtask

    task automatic test_patterns();
        win_t       w [3];
        logic [7:0] exp_do [3];
        int         lat, bc;
        bit         to;
        w[0] = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        w[1] = '{8'd7, 8'd7, 8'd7, 8'd0, 8'd255, 8'd255, 8'd0, 8'd7, 8'd3};
        w[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        exp_do = '{8'd5, 8'd7, 8'd255};
        for (int t = 0; t < 3; t++) begin
            send_window(w[t], 0, 0);
            wait_done(lat, bc, to);
            n_compared++;
            if (to !== 1'b0 || DO !== exp_do[t]) begin
                n_mismatched++;
                $display("[TB] FAIL pattern_%0d: got %0d (timeout=%0b) expected %0d",
                         t, DO, to, exp_do[t]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_gaps();
        win_t w;
        int   lat, bc;
        bit   to;
        w = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        send_window(w, 1, 3);
        wait_done(lat, bc, to);
        n_compared++;
        if (to !== 1'b0 || lat !== 31) begin
            n_mismatched++;
            $display("[TB] FAIL gaps_latency: got %0d (timeout=%0b) expected 31", lat, to);
        end
        n_compared++;
        if (DO !== 8'd50) begin
            n_mismatched++;
            $display("[TB] FAIL gaps_do: got %0d expected 50", DO);
        end
        @(negedge CLK);
    endtask

    task automatic test_busy_ignored();
        win_t w;
        int   lat, bc;
        bit   to;
        w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_window(w, 0, 0);
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            DI  = 8'd200;
            DSI = BUSY;
            @(negedge CLK);
            if (DSO) begin
                to = 1'b0;
                break;
            end
        end
        DSI = 1'b0;
        n_compared++;
        if (to !== 1'b0 || DO !== 8'd5) begin
            n_mismatched++;
            $display("[TB] FAIL busy_first_do: got %0d (timeout=%0b) expected 5", DO, to);
        end
        w = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
        send_window(w, 0, 0);
        wait_done(lat, bc, to);
        n_compared++;
        if (to !== 1'b0 || DO !== 8'd4) begin
            n_mismatched++;
            $display("[TB] FAIL busy_second_do: got %0d (timeout=%0b) expected 4", DO, to);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_load();
        win_t w;
        int   lat, bc;
        bit   to;
        for (int i = 0; i < 5; i++) send_sample(8'd100);
        RST = 1'b1;
        #1;
        n_compared++;
        if (DO !== 8'd0 || DSO !== 1'b0 || BUSY !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_load_outputs: got DO=%0d DSO=%0b BUSY=%0b expected 0/0/0",
                     DO, DSO, BUSY);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_window(w, 0, 0);
        wait_done(lat, bc, to);
        n_compared++;
        if (to !== 1'b0 || lat !== 31 || DO !== 8'd5) begin
            n_mismatched++;
            $display("[TB] FAIL rst_load_next: got DO=%0d lat=%0d expected DO=5 lat=31", DO, lat);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_sort();
        win_t w;
        int   lat, bc, pulses;
        bit   to;
        w = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
        send_window(w, 0, 0);
        repeat (10) @(negedge CLK);
        n_compared++;
        if (BUSY !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rst_sort_busy_before: got %0b expected 1", BUSY);
        end
        RST = 1'b1;
        #1;
        n_compared++;
        if (DO !== 8'd0 || DSO !== 1'b0 || BUSY !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_sort_outputs: got DO=%0d DSO=%0b BUSY=%0b expected 0/0/0",
                     DO, DSO, BUSY);
        end
        @(negedge CLK);
        RST = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (DSO) pulses++;
        end
        n_compared++;
        if (pulses !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_sort_no_dso: got %0d pulses expected 0", pulses);
        end
        w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_window(w, 0, 0);
        wait_done(lat, bc, to);
        n_compared++;
        if (to !== 1'b0 || DO !== 8'd5) begin
            n_mismatched++;
            $display("[TB] FAIL rst_sort_next: got %0d (timeout=%0b) expected 5", DO, to);
        end
    endtask

    // Random windows; some start on the DSO cycle itself, some use a narrow
    // value range to force many ties.
    task automatic test_random();
        win_t       w;
        logic [7:0] exp_do;
        int         lat, bc;
        bit         to;
        bit         bad;
        bad = 1'b0;
        for (int n = 0; n < 1000 && !bad; n++) begin
            for (int i = 0; i < 9; i++) begin
                if (n % 3 == 0) w[i] = 8'($urandom_range(0, 7));
                else            w[i] = 8'($urandom_range(0, 255));
            end
            exp_do = model_median(w);
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 2)) @(negedge CLK);
            end
            send_window(w, 0, $urandom_range(0, 3));
            wait_done(lat, bc, to);
            n_compared++;
            if (to !== 1'b0 || DO !== exp_do) begin
                n_mismatched++;
                bad = 1'b1;
                $display("[TB] FAIL random_window_%0d: got %0d (timeout=%0b) expected %0d",
                         n, DO, to, exp_do);
            end
        end
        if (!bad) $display("[TB] random windows: all medians matched the model");
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_ascending();
        test_patterns();
        test_gaps();
        test_busy_ignored();
        test_reset_mid_load();
        test_reset_mid_sort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
